// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: start handshake, operands, mode,
// status flags and the registered result.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic             SUB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] SUM;
  logic             COUT;
  logic             OVF;

  modport master (
    output start, A, B, CIN, SUB,
    input  busy, done, SUM, COUT, OVF
  );

  modport slave (
    input  start, A, B, CIN, SUB,
    output busy, done, SUM, COUT, OVF
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder bit per clock, LSB first,
// result published after WIDTH RUN cycles with a one-cycle done pulse.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             bit_s, bit_c;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    bit_s   = a_q[0] ^ b_q[0] ^ carry_q;
    bit_c   = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          // Subtraction is A + ~B + 1, so the mode only changes the load.
          a_d     = bus.A;
          b_d     = bus.SUB ? ~bus.B : bus.B;
          carry_d = bus.SUB | bus.CIN;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = bit_c;
        res_d   = (res_q >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // carry_q here is the carry into the MSB.
          sum_d   = res_d;
          cout_d  = bit_c;
          ovf_d   = carry_q ^ bit_c;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.SUM  = sum_q;
  assign bus.COUT = cout_q;
  assign bus.OVF  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 main instance, WIDTH=1 corner
// instance) against an arithmetic reference model.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_if #(.WIDTH(8)) bus ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Returns {cout, ovf, sum[31:0]} of the w-bit add/subtract.
  function automatic logic [33:0] model(input int unsigned w, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin,
                                        input logic sub);
    longint unsigned mask, aa, bb, tot, s;
    logic co, ov;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, a} & mask;
    bb   = {32'd0, b};
    bb   = sub ? (~bb & mask) : (bb & mask);
    tot  = aa + bb + (sub ? 64'd1 : {63'd0, cin});
    s    = tot & mask;
    co   = ((tot >> w) & 64'd1) != 0;
    ov   = (((aa >> (w - 1)) & 64'd1) == ((bb >> (w - 1)) & 64'd1)) &&
           (((s >> (w - 1)) & 64'd1) != ((aa >> (w - 1)) & 64'd1));
    return {co, ov, s[31:0]};
  endfunction

  // Drives one start and steps to the edge where the result should appear.
  // fin = {done, busy, SUM, COUT, OVF} sampled after edge T0+8.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, input bit noise, output logic [11:0] fin,
                        output int busy_cyc, output int done_cyc, output bit held);
    logic [9:0] old;
    old      = {bus.SUM, bus.COUT, bus.OVF};
    busy_cyc = 0;
    done_cyc = 0;
    held     = 1'b1;
    bus.start = 1'b1; bus.A = a; bus.B = b; bus.CIN = cin; bus.SUB = sub;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus.busy) busy_cyc++;
      if (bus.done) done_cyc++;
      if ({bus.SUM, bus.COUT, bus.OVF} !== old) held = 1'b0;
      if (noise) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.A = 8'($urandom); bus.B = 8'($urandom);
        bus.CIN = 1'($urandom); bus.SUB = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    fin = {bus.done, bus.busy, bus.SUM, bus.COUT, bus.OVF};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1; bus.A = 8'hA5; bus.B = 8'h5A; bus.CIN = 1'b1; bus.SUB = 1'b0;
    bus1.start = 1'b1; bus1.A = 1'b1; bus1.B = 1'b1; bus1.CIN = 1'b1; bus1.SUB = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({bus.busy, bus.done, bus.SUM, bus.COUT, bus.OVF} !== 12'h000) begin
      fails++;
      $display("FAIL reset_w8: got %h want 000", {bus.busy, bus.done, bus.SUM, bus.COUT, bus.OVF});
    end
    tests++;
    if ({bus1.busy, bus1.done, bus1.SUM, bus1.COUT, bus1.OVF} !== 5'h00) begin
      fails++;
      $display("FAIL reset_w1: got %h want 00", {bus1.busy, bus1.done, bus1.SUM, bus1.COUT, bus1.OVF});
    end
    bus.start = 1'b0; bus1.start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] ta[6]   = '{8'h3C, 8'hFF, 8'h7F, 8'h05, 8'h80, 8'h05};
    logic [7:0] tb_v[6] = '{8'h25, 8'h01, 8'h01, 8'h07, 8'h01, 8'h07};
    logic       tci[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       tsb[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] tsum[6] = '{8'h61, 8'h01, 8'h80, 8'hFE, 8'h7F, 8'hFE};
    logic       tco[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       tov[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [11:0] fin;
    int bc, dc;
    bit held;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb_v[i], tci[i], tsb[i], 1'b0, fin, bc, dc, held);
      tests++;
      if (fin !== {2'b10, tsum[i], tco[i], tov[i]}) begin
        fails++;
        $display("FAIL directed_%0d: got %h want %h", i, fin, {2'b10, tsum[i], tco[i], tov[i]});
      end
      tests++;
      if (bc != 8 || dc != 0 || !held) begin
        fails++;
        $display("FAIL directed_run_%0d: busy_cycles=%0d done_early=%0d held=%0d want 8/0/1", i, bc, dc, held);
      end
      @(posedge clk); #1;
      tests++;
      if ({bus.done, bus.busy, bus.SUM} !== {2'b00, tsum[i]}) begin
        fails++;
        $display("FAIL directed_idle_%0d: got %h want %h", i, {bus.done, bus.busy, bus.SUM}, {2'b00, tsum[i]});
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] fin;
    logic [33:0] m;
    logic [7:0] a, b;
    logic cin, sub;
    int bc, dc;
    bit held;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      m = model(8, 32'(a), 32'(b), cin, sub);
      run_op(a, b, cin, sub, (i % 2) == 1, fin, bc, dc, held);
      tests++;
      if (fin !== {2'b10, m[7:0], m[33], m[32]}) begin
        fails++;
        $display("FAIL random_%0d a=%h b=%h cin=%0d sub=%0d: got %h want %h", i, a, b, cin, sub,
                 fin, {2'b10, m[7:0], m[33], m[32]});
      end
      tests++;
      if (bc != 8 || dc != 0 || !held) begin
        fails++;
        $display("FAIL random_run_%0d: busy_cycles=%0d done_early=%0d held=%0d want 8/0/1", i, bc, dc, held);
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] fin;
    logic [33:0] m;
    int bc, dc, t1, t2;
    bit held;
    @(posedge clk); #1;
    run_op(8'h12, 8'h34, 1'b1, 1'b0, 1'b0, fin, bc, dc, held);
    t1 = cyc;
    tests++;
    if (fin !== {2'b10, 8'h47, 2'b00}) begin
      fails++;
      $display("FAIL b2b_first: got %h want %h", fin, {2'b10, 8'h47, 2'b00});
    end
    m = model(8, 32'h9C, 32'hE3, 1'b0, 1'b1);
    run_op(8'h9C, 8'hE3, 1'b0, 1'b1, 1'b0, fin, bc, dc, held);
    t2 = cyc;
    tests++;
    if (fin !== {2'b10, m[7:0], m[33], m[32]}) begin
      fails++;
      $display("FAIL b2b_second: got %h want %h", fin, {2'b10, m[7:0], m[33], m[32]});
    end
    tests++;
    if (t2 - t1 != 9 || bc != 8 || dc != 0 || !held) begin
      fails++;
      $display("FAIL b2b_timing: gap=%0d busy=%0d done_early=%0d held=%0d want 9/8/0/1", t2 - t1, bc, dc, held);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [11:0] fin;
    int bc, dc, early;
    bit held;
    @(posedge clk); #1;
    run_op(8'h3C, 8'h25, 1'b0, 1'b0, 1'b0, fin, bc, dc, held);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.A = 8'hF0; bus.B = 8'h0F; bus.CIN = 1'b1; bus.SUB = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    early = 0;
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus.done || !bus.busy) early++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if ({early[3:0], bus.busy, bus.done, bus.SUM, bus.COUT, bus.OVF} !== 16'h0000) begin
      fails++;
      $display("FAIL reset_mid_op: bad_run=%0d got %h want 000", early,
               {bus.busy, bus.done, bus.SUM, bus.COUT, bus.OVF});
    end
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, fin, bc, dc, held);
    tests++;
    if (fin !== {2'b10, 8'h80, 2'b01} || bc != 8 || dc != 0 || !held) begin
      fails++;
      $display("FAIL after_reset_op: got %h busy=%0d done_early=%0d held=%0d want %h/8/0/1",
               fin, bc, dc, held, {2'b10, 8'h80, 2'b01});
    end
  endtask

  task automatic test_width1();
    logic [33:0] m;
    logic [2:0] c;
    logic cin;
    for (int i = 0; i < 8; i++) begin
      c = 3'(i);
      cin = 1'($urandom);
      m = model(1, {31'd0, c[0]}, {31'd0, c[1]}, cin, c[2]);
      bus1.start = 1'b1; bus1.A = c[0]; bus1.B = c[1]; bus1.CIN = cin; bus1.SUB = c[2];
      @(posedge clk); #1;
      bus1.start = 1'b0;
      tests++;
      if ({bus1.busy, bus1.done} !== 2'b10) begin
        fails++;
        $display("FAIL w1_busy_%0d: got %b want 10", i, {bus1.busy, bus1.done});
      end
      @(posedge clk); #1;
      tests++;
      if ({bus1.done, bus1.busy, bus1.SUM, bus1.COUT, bus1.OVF} !== {2'b10, m[0], m[33], m[32]}) begin
        fails++;
        $display("FAIL w1_result_%0d: got %b want %b", i,
                 {bus1.done, bus1.busy, bus1.SUM, bus1.COUT, bus1.OVF}, {2'b10, m[0], m[33], m[32]});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    test_width1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
